// File: rtl/trace_event_packer.sv
// trace_event_packer
//   Turns per-cycle match-rule hits into timestamped sniff-FIFO entries.
//   A MATCH entry (cmd 01) carries a short elapsed time and the rule index.
//   A TIME entry (cmd 10) carrying the full elapsed time is written just
//   before a MATCH whose elapsed time does not fit in the short field.
//   The host rebuilds absolute time as: last TIME value + MATCH short time.
//
// Ports
//   trace_clk         in   trace clock, rising edge
//   resetn            in   asynchronous active-low reset
//   I_arm             in   pulse: start capture, clear time and sticky flags
//   I_stop            in   pulse: stop capture (wins over I_arm)
//   I_match           in   per-rule hit vector
//   I_pattern_enable  in   per-rule enable vector
//   I_fifo_full       in   sniff FIFO cannot take a write this cycle
//   O_fifo_wr         out  write strobe, one cycle per entry
//   O_fifo_data       out  entry: [1:0] cmd, [17:2] payload
//   O_capturing       out  high while ARMED or PEND
//   O_overflow        out  sticky: an entry was dropped on a full FIFO
//   O_lost            out  sticky: a hit arrived during PEND and was discarded
//   O_event_count     out  accepted hits since arm, saturating
module trace_event_packer #(
    parameter int pRULES   = 8,
    parameter int pSHORT_W = 6,
    parameter int pFULL_W  = 16
) (
    input  logic              trace_clk,
    input  logic              resetn,
    input  logic              I_arm,
    input  logic              I_stop,
    input  logic [pRULES-1:0] I_match,
    input  logic [pRULES-1:0] I_pattern_enable,
    input  logic              I_fifo_full,
    output logic              O_fifo_wr,
    output logic [17:0]       O_fifo_data,
    output logic              O_capturing,
    output logic              O_overflow,
    output logic              O_lost,
    output logic [15:0]       O_event_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PEND  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [pFULL_W-1:0] cnt_q;
    logic [7:0]         rule_q;
    logic               ovf_q, lost_q;
    logic [15:0]        evt_q;

    logic               vld_p1;
    logic [17:0]        data_p1;

    logic [pRULES-1:0]  hit_vec;
    logic               hit_any;
    logic [7:0]         hit_idx;
    logic               do_arm;
    logic               hold;
    logic               accept;
    logic               lost_ev;
    logic               fits_short;
    logic               ent_vld;
    logic [17:0]        ent_data;

    function automatic logic [pFULL_W-1:0] sat_inc_time(input logic [pFULL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc_evt(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [17:0] make_match(input logic [pSHORT_W-1:0] s,
                                               input logic [7:0]          r);
        logic [17:0] d;
        d                   = '0;
        d[1:0]              = 2'b01;
        d[2 +: pSHORT_W]    = s;
        d[2+pSHORT_W +: 8]  = r;
        return d;
    endfunction

    function automatic logic [17:0] make_time(input logic [pFULL_W-1:0] t);
        return {16'(t), 2'b10};
    endfunction

    assign hit_vec    = I_match & I_pattern_enable;
    assign hit_any    = |hit_vec;
    assign do_arm     = I_arm & ~I_stop;
    // Arm or stop this cycle overrides whatever the FSM would otherwise do.
    assign hold       = ~I_arm & ~I_stop;
    assign accept     = (state_q == ARMED) & hit_any & hold;
    assign lost_ev    = (state_q == PEND) & hit_any & hold;
    assign fits_short = (cnt_q >> pSHORT_W) == '0;

    // Lowest-index enabled hit wins.
    always_comb begin
        hit_idx = '0;
        for (int i = pRULES - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = 8'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        if (I_stop) begin
            state_d = IDLE;
        end else if (I_arm) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED:   if (accept && !fits_short) state_d = PEND;
                PEND:    state_d = ARMED;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        ent_vld  = 1'b0;
        ent_data = '0;
        if (accept) begin
            ent_vld  = 1'b1;
            ent_data = fits_short ? make_match(cnt_q[pSHORT_W-1:0], hit_idx)
                                  : make_time(cnt_q);
        end else if (state_q == PEND && hold) begin
            ent_vld  = 1'b1;
            ent_data = make_match('0, rule_q);
        end
    end

    // ---- stage p0 -> p1: register the entry and the control state ----
    always_ff @(posedge trace_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rule_q  <= '0;
            ovf_q   <= 1'b0;
            lost_q  <= 1'b0;
            evt_q   <= '0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            state_q <= state_d;
            vld_p1  <= ent_vld;
            if (ent_vld) data_p1 <= ent_data;
            if (do_arm) begin
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
                lost_q <= 1'b0;
                evt_q  <= '0;
            end else begin
                if (state_q != IDLE) cnt_q <= accept ? pFULL_W'(1) : sat_inc_time(cnt_q);
                // The drop is decided in the cycle the strobe would be issued.
                if (vld_p1 && I_fifo_full) ovf_q <= 1'b1;
                if (lost_ev) lost_q <= 1'b1;
                if (accept) begin
                    evt_q  <= sat_inc_evt(evt_q);
                    rule_q <= hit_idx;
                end
            end
        end
    end

    assign O_fifo_wr     = vld_p1 & ~I_fifo_full;
    assign O_fifo_data   = data_p1;
    assign O_capturing   = (state_q != IDLE);
    assign O_overflow    = ovf_q;
    assign O_lost        = lost_q;
    assign O_event_count = evt_q;

endmodule

// File: tb/tb_trace_event_packer.sv
// Testbench for trace_event_packer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_trace_event_packer;

    logic        trace_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        I_arm = 1'b0;
    logic        I_stop = 1'b0;
    logic [7:0]  I_match = '0;
    logic [7:0]  I_pattern_enable = '0;
    logic        I_fifo_full = 1'b0;
    logic        O_fifo_wr;
    logic [17:0] O_fifo_data;
    logic        O_capturing;
    logic        O_overflow;
    logic        O_lost;
    logic [15:0] O_event_count;

    trace_event_packer #(.pRULES(8), .pSHORT_W(6), .pFULL_W(16)) dut (
        .trace_clk        (trace_clk),
        .resetn           (resetn),
        .I_arm            (I_arm),
        .I_stop           (I_stop),
        .I_match          (I_match),
        .I_pattern_enable (I_pattern_enable),
        .I_fifo_full      (I_fifo_full),
        .O_fifo_wr        (O_fifo_wr),
        .O_fifo_data      (O_fifo_data),
        .O_capturing      (O_capturing),
        .O_overflow       (O_overflow),
        .O_lost           (O_lost),
        .O_event_count    (O_event_count)
    );

    always #5 trace_clk = ~trace_clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: elapsed time as an integer, and a queue of entries
    // still to be presented (a non-empty queue means a MATCH is pending).
    bit          m_cap;
    int          m_t;
    bit          m_ovf;
    bit          m_lost;
    int          m_cnt;
    logic [17:0] m_future[$];
    bit          m_vld;
    logic [17:0] m_out;

    function automatic int sat16(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    function automatic int lowest(input logic [7:0] h);
        for (int i = 0; i < 8; i++) if (h[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_cap = 0; m_t = 0; m_ovf = 0; m_lost = 0; m_cnt = 0;
        m_future.delete();
        m_vld = 0; m_out = '0;
    endtask

    task automatic model_step();
        logic [7:0] h;
        int idx;
        h = I_match & I_pattern_enable;
        if (m_vld && I_fifo_full && !(I_arm && !I_stop)) m_ovf = 1;
        if (I_stop) begin
            m_cap = 0;
            m_future.delete();
        end else if (I_arm) begin
            m_cap = 1; m_t = 0; m_ovf = 0; m_lost = 0; m_cnt = 0;
            m_future.delete();
        end else if (m_cap) begin
            if (m_future.size() > 0) begin
                if (h != 0) m_lost = 1;
                m_t = sat16(m_t + 1);
            end else if (h != 0) begin
                idx = lowest(h);
                m_cnt = sat16(m_cnt + 1);
                if (m_t < 64) begin
                    m_future.push_back({2'b00, 8'(idx), 6'(m_t), 2'b01});
                end else begin
                    m_future.push_back({16'(m_t), 2'b10});
                    m_future.push_back({2'b00, 8'(idx), 6'd0, 2'b01});
                end
                m_t = 1;
            end else begin
                m_t = sat16(m_t + 1);
            end
        end
        if (m_future.size() > 0) begin
            m_vld = 1;
            m_out = m_future.pop_front();
        end else begin
            m_vld = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_wr;
        exp_wr = m_vld && !I_fifo_full;
        check("fifo_wr", 32'(O_fifo_wr), 32'(exp_wr));
        if (exp_wr) check("fifo_data", 32'(O_fifo_data), 32'(m_out));
        check("capturing", 32'(O_capturing), 32'(m_cap));
        check("overflow", 32'(O_overflow), 32'(m_ovf));
        check("lost", 32'(O_lost), 32'(m_lost));
        check("event_count", 32'(O_event_count), 32'(m_cnt));
    endtask

    task automatic cyc(input bit arm, input bit stop, input logic [7:0] m,
                       input logic [7:0] en, input bit full);
        @(negedge trace_clk);
        I_arm = arm; I_stop = stop; I_match = m; I_pattern_enable = en; I_fifo_full = full;
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 8'hFF, 0);
    endtask

    task automatic hit(input int rule);
        cyc(0, 0, 8'(1 << rule), 8'hFF, 0);
    endtask

    task automatic arm();
        cyc(1, 0, 8'h00, 8'hFF, 0);
    endtask

    task automatic apply_reset();
        @(negedge trace_clk);
        resetn = 1'b0;
        I_arm = 0; I_stop = 0; I_match = '0; I_pattern_enable = '0; I_fifo_full = 0;
        #1;
        model_reset();
        check_outputs();
        check("rst_fifo_wr", 32'(O_fifo_wr), 32'd0);
        check("rst_data", 32'(O_fifo_data), 32'd0);
        #1;
        resetn = 1'b1;
        model_step();
    endtask

    initial begin
        apply_reset();
        idle(3);

        // Short-time MATCH on rule 3.
        arm();
        idle(10);
        hit(3);
        idle(3);

        // Long gap: TIME then MATCH on back-to-back cycles.
        arm();
        idle(100);
        hit(0);
        idle(3);

        // Simultaneous hits on rules 5 and 2.
        cyc(0, 0, 8'b0010_0100, 8'hFF, 0);
        idle(2);
        // Disabled rule ignored, enabled rule 6 taken.
        cyc(0, 0, 8'b0100_0010, 8'b0100_0000, 0);
        idle(2);

        // Consecutive hits, then a long gap hit followed by a hit during PEND.
        arm();
        idle(5);
        hit(1);
        hit(4);
        idle(80);
        hit(7);
        hit(2);
        idle(3);

        // FIFO full on the write cycle; re-arm clears overflow.
        arm();
        idle(4);
        hit(6);
        cyc(0, 0, 8'h00, 8'hFF, 1);
        idle(2);
        arm();
        idle(2);

        // Stop during PEND abandons the MATCH.
        idle(70);
        hit(3);
        cyc(0, 1, 8'h00, 8'hFF, 0);
        idle(3);
        // Stop wins over arm.
        cyc(1, 1, 8'h00, 8'hFF, 0);
        idle(2);

        // Saturated time, then reset mid-PEND.
        arm();
        idle(70000);
        hit(5);
        apply_reset();
        idle(4);

        // Randomized traffic.
        arm();
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 500; i++) begin
                bit          a, s, f;
                logic [7:0]  m, en;
                a  = ($urandom_range(0, 99) == 0);
                s  = ($urandom_range(0, 149) == 0);
                f  = ($urandom_range(0, 7) == 0);
                m  = ($urandom_range(0, 99) < (blk * 8 + 2)) ? 8'($urandom) : 8'h00;
                en = (blk == 3) ? 8'($urandom) : 8'hFF;
                cyc(a, s, m, en, f);
                if (!m_cap && $urandom_range(0, 19) == 0) arm();
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
